// File: rtl/shifter_pkg.sv
// Shared op codes, shift-kind decode and layer-group partitioning for the pipelined barrel
// shifter.
package shifter_pkg;

    localparam logic [2:0] OP_SRA      = 3'b000;
    localparam logic [2:0] OP_SLL      = 3'b001;
    localparam logic [2:0] OP_SRL      = 3'b010;
    localparam logic [2:0] OP_SLL_ALT  = 3'b011;
    localparam logic [2:0] OP_ROR      = 3'b100;
    localparam logic [2:0] OP_ROL      = 3'b101;
    localparam logic [2:0] OP_PASS     = 3'b110;
    localparam logic [2:0] OP_PASS_ALT = 3'b111;

    typedef enum logic [2:0] {
        KindSra,
        KindSrl,
        KindSll,
        KindRor,
        KindRol,
        KindPass
    } shift_kind_e;

    function automatic shift_kind_e decode_op(input logic [2:0] op);
        case (op)
            OP_SRA:             return KindSra;
            OP_SRL:             return KindSrl;
            OP_SLL, OP_SLL_ALT: return KindSll;
            OP_ROR:             return KindRor;
            OP_ROL:             return KindRol;
            default:            return KindPass;
        endcase
    endfunction

    // First layer index of group idx; group idx covers [grp_bound(idx), grp_bound(idx+1)).
    function automatic int unsigned grp_bound(input int unsigned shw, input int unsigned stages,
                                              input int unsigned idx);
        int unsigned per;
        per = (shw + stages - 1) / stages;
        return (idx * per > shw) ? shw : idx * per;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One pipeline stage: applies shift layers LO..HI-1 to the incoming beat, then registers the
// result with a valid bit and local ready logic.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5,
    parameter int unsigned LO    = 0,
    parameter int unsigned HI    = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   amt_i,
    input  logic [2:0]       op_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   amt_o,
    output logic [2:0]       op_o,
    output logic             carry_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   amt_q;
    logic [2:0]       op_q;
    logic             carry_q, carry_d;
    shift_kind_e      kind;
    logic [SHW-1:0]   sel;
    logic [WIDTH-1:0] tmp;
    int               s;

    always_comb begin
        data_d  = data_i;
        carry_d = carry_i;
        kind    = decode_op(op_i);
        sel     = '0;
        tmp     = '0;
        s       = 0;
        for (int k = 0; k < int'(SHW); k++) begin
            sel = amt_i >> k;
            if (k >= int'(LO) && k < int'(HI) && sel[0]) begin
                s = 1 << k;
                // Carry is the last bit leaving the word in this layer; later layers overwrite it.
                case (kind)
                    KindSra: begin
                        tmp     = data_d >> (s - 1);
                        carry_d = tmp[0];
                        data_d  = $signed(data_d) >>> s;
                    end
                    KindSrl: begin
                        tmp     = data_d >> (s - 1);
                        carry_d = tmp[0];
                        data_d  = data_d >> s;
                    end
                    KindSll: begin
                        tmp     = data_d >> (WIDTH - s);
                        carry_d = tmp[0];
                        data_d  = data_d << s;
                    end
                    KindRor: begin
                        data_d  = (data_d >> s) | (data_d << (WIDTH - s));
                        carry_d = data_d[WIDTH-1];
                    end
                    KindRol: begin
                        data_d  = (data_d << s) | (data_d >> (WIDTH - s));
                        carry_d = data_d[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ready_o = !valid_q || ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            if (ready_o) begin
                valid_q <= valid_i;
            end
            if (valid_i && ready_o) begin
                data_q  <= data_d;
                amt_q   <= amt_i;
                op_q    <= op_i;
                carry_q <= carry_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign op_o    = op_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with shift/rotate modes, carry and zero flags and valid/ready
// handshakes; STAGES register stages each applying a contiguous group of shift layers.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SHW    = $clog2(WIDTH),
    parameter int unsigned STAGES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [SHW-1:0]   in_b_i,
    input  logic [2:0]       in_op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_c_o,
    output logic             out_carry_o,
    output logic             out_zero_o
);

    logic             valid [STAGES+1];
    logic             ready [STAGES+1];
    logic [WIDTH-1:0] data  [STAGES+1];
    logic [SHW-1:0]   amt   [STAGES+1];
    logic [2:0]       op    [STAGES+1];
    logic             carry [STAGES+1];

    assign valid[0]       = in_valid_i;
    assign data[0]        = in_a_i;
    assign amt[0]         = in_b_i;
    assign op[0]          = in_op_i;
    assign carry[0]       = 1'b0;
    assign ready[STAGES]  = out_ready_i;
    assign in_ready_o     = ready[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .LO    (grp_bound(SHW, STAGES, i)),
            .HI    (grp_bound(SHW, STAGES, i + 1))
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .valid_i (valid[i]),
            .ready_o (ready[i]),
            .data_i  (data[i]),
            .amt_i   (amt[i]),
            .op_i    (op[i]),
            .carry_i (carry[i]),
            .valid_o (valid[i+1]),
            .ready_i (ready[i+1]),
            .data_o  (data[i+1]),
            .amt_o   (amt[i+1]),
            .op_o    (op[i+1]),
            .carry_o (carry[i+1])
        );
    end

    assign out_valid_o = valid[STAGES];
    assign out_c_o     = data[STAGES];
    assign out_carry_o = carry[STAGES];
    // Qualified by valid so the flag reads 0 out of reset, when the result register is 0.
    assign out_zero_o  = valid[STAGES] && (data[STAGES] == '0);

endmodule
